// File: rtl/path_verifier_pkg.sv
// rtl/path_verifier_pkg.sv - shared states, error codes and cell constants for path_verifier
package path_verifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MOVE,
        ST_READ,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_ADJ     = 3'd2;
    localparam logic [2:0] ERR_WALL    = 3'd3;
    localparam logic [2:0] ERR_END     = 3'd4;
    localparam logic [2:0] ERR_REVISIT = 3'd5;
    localparam logic [2:0] ERR_OVF     = 3'd6;

    localparam int         MAZE_DIM   = 16;
    localparam logic [7:0] START_CELL = 8'h00;
    localparam logic [7:0] GOAL_CELL  = 8'hFF;

    // Unsigned absolute differences, so row/col 15 and 0 are never neighbours.
    function automatic logic is_adjacent(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] dr;
        logic [3:0] dc;
        dr = (a[7:4] >= b[7:4]) ? (a[7:4] - b[7:4]) : (b[7:4] - a[7:4]);
        dc = (a[3:0] >= b[3:0]) ? (a[3:0] - b[3:0]) : (b[3:0] - a[3:0]);
        return ({1'b0, dr} + {1'b0, dc}) == 5'd1;
    endfunction

endpackage

// File: rtl/path_visited_map.sv
// rtl/path_visited_map.sv - 256-cell visited bitmap with set, query and clear
module path_visited_map (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       set_en,
    input  logic [7:0] set_idx,
    input  logic [7:0] query_idx,
    output logic       hit
);

    logic [255:0] bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits <= '0;
        end else if (clear) begin
            bits <= '0;
        end else if (set_en) begin
            bits[set_idx] <= 1'b1;
        end
    end

    assign hit = bits[query_idx];

endmodule

// File: rtl/path_verifier.sv
// rtl/path_verifier.sv - checks a streamed maze path; revisit check enabled by PATH_VERIFIER_REVISIT_CHK_EN
module path_verifier
    import path_verifier_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                move_valid,
    output logic                move_ready,
    input  logic [7:0]          move,
    input  logic                move_last,
    output logic                maze_rd,
    output logic [3:0]          maze_addr,
    input  logic [MAZE_DIM-1:0] maze_data,
    output logic                done,
    output logic                ok,
    output logic [2:0]          err_code,
    output logic [7:0]          step_count
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cur_cell;
    logic       cur_last;
    logic [7:0] prev_cell;
    logic [7:0] steps;
    logic [2:0] err_reg;
    logic [2:0] chk_err;
    logic       revisit_hit;
    logic       chk_pass;

`ifdef PATH_VERIFIER_REVISIT_CHK_EN
    path_visited_map u_visited (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .set_en    (state == ST_CHECK && chk_pass),
        .set_idx   (cur_cell),
        .query_idx (cur_cell),
        .hit       (revisit_hit)
    );
`else
    assign revisit_hit = 1'b0;
`endif

    // maze_data holds the captured row during CHECK; first failing test wins.
    always_comb begin
        chk_err = ERR_NONE;
        if (steps == 8'd0 && cur_cell != START_CELL) begin
            chk_err = ERR_START;
        end else if (steps != 8'd0 && !is_adjacent(cur_cell, prev_cell)) begin
            chk_err = ERR_ADJ;
        end else if (maze_data[cur_cell[3:0]]) begin
            chk_err = ERR_WALL;
        end else if (revisit_hit) begin
            chk_err = ERR_REVISIT;
        end else if (steps == 8'hFF) begin
            chk_err = ERR_OVF;
        end
    end

    assign chk_pass = (chk_err == ERR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_WAIT_MOVE;
        end else begin
            case (state)
                ST_WAIT_MOVE: if (move_valid) state_nxt = ST_READ;
                ST_READ:      state_nxt = ST_CHECK;
                ST_CHECK: begin
                    if (!chk_pass)                  state_nxt = ST_FAIL;
                    else if (!cur_last)             state_nxt = ST_WAIT_MOVE;
                    else if (cur_cell == GOAL_CELL) state_nxt = ST_PASS;
                    else                            state_nxt = ST_FAIL;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        move_ready = (state == ST_WAIT_MOVE);
        maze_rd    = (state == ST_READ);
        maze_addr  = (state == ST_READ) ? cur_cell[7:4] : 4'd0;
        done       = (state == ST_PASS) || (state == ST_FAIL);
        ok         = (state == ST_PASS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_cell  <= 8'd0;
            cur_last  <= 1'b0;
            prev_cell <= 8'd0;
            steps     <= 8'd0;
            err_reg   <= ERR_NONE;
        end else if (start) begin
            prev_cell <= 8'd0;
            steps     <= 8'd0;
            err_reg   <= ERR_NONE;
        end else if (state == ST_WAIT_MOVE && move_valid) begin
            cur_cell <= move;
            cur_last <= move_last;
        end else if (state == ST_CHECK) begin
            if (!chk_pass) begin
                err_reg <= chk_err;
            end else begin
                steps     <= steps + 8'd1;
                prev_cell <= cur_cell;
                if (cur_last && cur_cell != GOAL_CELL) begin
                    err_reg <= ERR_END;
                end
            end
        end
    end

    assign err_code   = err_reg;
    assign step_count = steps;

endmodule

// File: tb/tb_path_verifier.sv
// tb/tb_path_verifier.sv - scoreboard bench for path_verifier
module tb_path_verifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        move_valid;
    logic        move_ready;
    logic [7:0]  move;
    logic        move_last;
    logic        maze_rd;
    logic [3:0]  maze_addr;
    logic [15:0] maze_data = 16'h0000;
    logic        done;
    logic        ok;
    logic [2:0]  err_code;
    logic [7:0]  step_count;

    typedef struct packed {
        logic       ok;
        logic [2:0] err;
        logic [7:0] steps;
    } verdict_t;

    logic [15:0] maze_mem [16];
    logic [7:0]  path_q [$];
    verdict_t    sb_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    path_verifier dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move       (move),
        .move_last  (move_last),
        .maze_rd    (maze_rd),
        .maze_addr  (maze_addr),
        .maze_data  (maze_data),
        .done       (done),
        .ok         (ok),
        .err_code   (err_code),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (maze_rd) maze_data <= maze_mem[maze_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic verdict_t model();
        verdict_t     v;
        logic [255:0] vis;
        logic [7:0]   prev;
        logic [7:0]   c;
        logic [15:0]  row;
        int           dr;
        int           dc;
        v    = '0;
        vis  = '0;
        prev = 8'h00;
        for (int i = 0; i < path_q.size(); i++) begin
            c  = path_q[i];
            dr = int'(c[7:4]) - int'(prev[7:4]);
            dc = int'(c[3:0]) - int'(prev[3:0]);
            if (dr < 0) dr = -dr;
            if (dc < 0) dc = -dc;
            row = maze_mem[c[7:4]];
            if (v.steps == 0 && c != 8'h00) begin v.err = 3'd1; return v; end
            if (v.steps != 0 && dr + dc != 1) begin v.err = 3'd2; return v; end
            if (row[c[3:0]]) begin v.err = 3'd3; return v; end
`ifdef PATH_VERIFIER_REVISIT_CHK_EN
            if (vis[c]) begin v.err = 3'd5; return v; end
`endif
            if (v.steps == 8'd255) begin v.err = 3'd6; return v; end
            vis[c]  = 1'b1;
            v.steps = v.steps + 8'd1;
            prev    = c;
            if (i == path_q.size() - 1) begin
                if (c == 8'hFF) v.ok = 1'b1;
                else            v.err = 3'd4;
            end
        end
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_moves(input string tag, input bit mark_last);
        int cyc;
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < path_q.size() && !aborted; i++) begin
            move       = path_q[i];
            move_last  = mark_last && (i == path_q.size() - 1);
            move_valid = 1'b1;
            cyc = 0;
            while (!move_ready && !done && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (done) aborted = 1'b1;
            else if (!move_ready) begin
                check_eq({tag, " ready_timeout"}, 32'(move_ready), 32'd1);
                aborted = 1'b1;
            end else @(negedge clk);
        end
        move_valid = 1'b0;
        move_last  = 1'b0;
    endtask

    task automatic run_path(input string tag, input verdict_t exp);
        int       cyc;
        verdict_t e;
        sb_q.push_back(exp);
        pulse_start();
        drive_moves(tag, 1'b1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check_eq({tag, " done"},  32'(done),       32'd1);
        check_eq({tag, " ok"},    32'(ok),         32'(e.ok));
        check_eq({tag, " err"},   32'(err_code),   32'(e.err));
        check_eq({tag, " steps"}, 32'(step_count), 32'(e.steps));
    endtask

    task automatic load_full_path();
        path_q.delete();
        for (int c = 0; c < 16; c++) path_q.push_back({4'd0, 4'(c)});
        for (int r = 1; r < 16; r++) path_q.push_back({4'(r), 4'd15});
    endtask

    task automatic gen_random_path(input int len);
        int r;
        int col;
        path_q.delete();
        r   = 0;
        col = 0;
        path_q.push_back(8'h00);
        for (int i = 1; i < len; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    if (r < 15) r++;
                2, 3, 4: if (col < 15) col++;
                5, 6:    if (r > 0) r--;
                7, 8:    if (col > 0) col--;
                default: begin r = $urandom_range(0, 15); col = $urandom_range(0, 15); end
            endcase
            path_q.push_back({4'(r), 4'(col)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        move_valid = 1'b0;
        move_last  = 1'b0;
        move       = 8'h00;
        for (int i = 0; i < 16; i++) maze_mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst move_ready", 32'(move_ready), 32'd0);
        check_eq("rst maze_rd",    32'(maze_rd),    32'd0);
        check_eq("rst maze_addr",  32'(maze_addr),  32'd0);
        check_eq("rst done",       32'(done),       32'd0);
        check_eq("rst ok",         32'(ok),         32'd0);
        check_eq("rst err_code",   32'(err_code),   32'd0);
        check_eq("rst step_count", 32'(step_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle move_ready", 32'(move_ready), 32'd0);

        load_full_path();
        run_path("open_maze", '{ok: 1'b1, err: 3'd0, steps: 8'd31});

        path_q = '{8'h00, 8'h11};
        run_path("diagonal", '{ok: 1'b0, err: 3'd2, steps: 8'd1});

        maze_mem[0] = 16'h0004;
        path_q = '{8'h00, 8'h01, 8'h02};
        run_path("wall", '{ok: 1'b0, err: 3'd3, steps: 8'd2});
        maze_mem[0] = 16'h0000;

        path_q = '{8'h01};
        run_path("bad_start", '{ok: 1'b0, err: 3'd1, steps: 8'd0});

        path_q = '{8'h00, 8'h01, 8'h00};
`ifdef PATH_VERIFIER_REVISIT_CHK_EN
        run_path("revisit", '{ok: 1'b0, err: 3'd5, steps: 8'd2});
`else
        run_path("revisit", '{ok: 1'b0, err: 3'd4, steps: 8'd3});
`endif

        path_q = '{8'h00};
        run_path("single", '{ok: 1'b0, err: 3'd4, steps: 8'd1});

        path_q = '{8'h00, 8'h0F};
        run_path("no_wrap", '{ok: 1'b0, err: 3'd2, steps: 8'd1});

        path_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        pulse_start();
        drive_moves("abort", 1'b0);
        repeat (2) @(negedge clk);
        check_eq("abort pre steps", 32'(step_count), 32'd5);
        pulse_start();
        check_eq("abort steps",      32'(step_count), 32'd0);
        check_eq("abort done",       32'(done),       32'd0);
        check_eq("abort move_ready", 32'(move_ready), 32'd1);
        load_full_path();
        run_path("after_abort", '{ok: 1'b1, err: 3'd0, steps: 8'd31});

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) maze_mem[i] = 16'($urandom & $urandom & $urandom);
            if (k < 6) maze_mem[0][0] = 1'b0;
            gen_random_path($urandom_range(2, 12));
            run_path($sformatf("rand%0d", k), model());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
